// File: rtl/ss_tx_16b_pkg.sv
// Shared types and constants for the ss_tx_16b serial word transmitter.
// The SS_TX_PARITY_EN build inserts an even-parity bit between data and stop.
package ss_tx_16b_pkg;

  localparam int DATA_W           = 16;
  localparam int FRAME_BITS_NOPAR = 18;
  localparam int FRAME_BITS_PAR   = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ss_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared and flags the
// terminal count both for the current cycle (tick) and the coming one (tick_next).
module ss_tx_baud
  import ss_tx_16b_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next count: held at zero while cleared, wraps after the terminal count.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r == TERM_CNT) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + ONE_CNT;
    end
  end

  // Period counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign tick      = (cnt_r == TERM_CNT);
  assign tick_next = (cnt_next_s == TERM_CNT);

endmodule

// File: rtl/ss_tx_16b.sv
// 16-bit serial transmitter: start bit, 16 data bits LSB first, stop bit.
// Define SS_TX_PARITY_EN to append an even-parity bit before the stop bit.
module ss_tx_16b
  import ss_tx_16b_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              tx_write,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              txd
);

  tx_state_e         state_r, state_next_s;
  logic [DATA_W-1:0] shreg_r, shreg_next_s;
  logic [3:0]        bit_idx_r, bit_idx_next_s;
  logic              tick_s, tick_next_s, clr_s;
  logic              txd_next_s;
  logic              txd_r, busy_r, ready_r, done_r;
`ifdef SS_TX_PARITY_EN
  logic              parity_r, parity_next_s;
`endif

  assign clr_s = (state_r == ST_IDLE);

  ss_tx_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk       (CLK),
    .rst_n     (reset),
    .clr       (clr_s),
    .tick      (tick_s),
    .tick_next (tick_next_s)
  );

  // Frame sequencing: load on accepted write, advance on bit-period ticks.
  always_comb begin
    state_next_s   = state_r;
    shreg_next_s   = shreg_r;
    bit_idx_next_s = bit_idx_r;
`ifdef SS_TX_PARITY_EN
    parity_next_s  = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (tx_write) begin
          state_next_s   = ST_START;
          shreg_next_s   = data;
          bit_idx_next_s = 4'd0;
`ifdef SS_TX_PARITY_EN
          parity_next_s  = even_parity(data);
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_next_s   = ST_DATA;
          bit_idx_next_s = 4'd0;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shreg_next_s = {1'b0, shreg_r[DATA_W-1:1]};
          if (bit_idx_r == 4'd15) begin
`ifdef SS_TX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            bit_idx_next_s = bit_idx_r + 4'd1;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef SS_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, taken from the state being entered.
  always_comb begin
    txd_next_s = 1'b1;
    case (state_next_s)
      ST_IDLE:   txd_next_s = 1'b1;
      ST_START:  txd_next_s = 1'b0;
      ST_DATA:   txd_next_s = shreg_next_s[0];
`ifdef SS_TX_PARITY_EN
      ST_PARITY: txd_next_s = parity_next_s;
`endif
      ST_STOP:   txd_next_s = 1'b1;
      default:   txd_next_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shreg_r   <= {DATA_W{1'b0}};
      bit_idx_r <= 4'd0;
`ifdef SS_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      shreg_r   <= shreg_next_s;
      bit_idx_r <= bit_idx_next_s;
`ifdef SS_TX_PARITY_EN
      parity_r  <= parity_next_s;
`endif
      txd_r     <= txd_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
      ready_r   <= (state_next_s == ST_IDLE);
      done_r    <= (state_next_s == ST_STOP) && tick_next_s;
    end
  end

  assign txd      = txd_r;
  assign tx_busy  = busy_r;
  assign tx_ready = ready_r;
  assign tx_done  = done_r;

endmodule

// File: tb/tb_ss_tx_16b.sv
// Self-checking bench for ss_tx_16b: two instances (4 and 1 clocks per bit)
// checked cycle by cycle against a frame model built from the frame format.
module tb_ss_tx_16b;

  logic        CLK;
  logic        reset;
  logic [15:0] data;
  logic        wr4, wr1;
  logic        txd4, rdy4, busy4, done4;
  logic        txd1, rdy1, busy1, done1;
  logic        sel;
  logic        txd_m, rdy_m, busy_m, done_m;

  int tests_run;
  int tests_failed;

  ss_tx_16b #(.CLKS_PER_BIT(4), .CNT_W(16)) dut4 (
    .CLK(CLK), .reset(reset), .data(data), .tx_write(wr4),
    .tx_ready(rdy4), .tx_busy(busy4), .tx_done(done4), .txd(txd4)
  );

  ss_tx_16b #(.CLKS_PER_BIT(1), .CNT_W(16)) dut1 (
    .CLK(CLK), .reset(reset), .data(data), .tx_write(wr1),
    .tx_ready(rdy1), .tx_busy(busy1), .tx_done(done1), .txd(txd1)
  );

  assign txd_m  = sel ? txd1  : txd4;
  assign rdy_m  = sel ? rdy1  : rdy4;
  assign busy_m = sel ? busy1 : busy4;
  assign done_m = sel ? done1 : done4;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One frame on the selected instance, starting from an idle negedge and
  // ending on the negedge of the first ready cycle after the frame.
  task automatic send_frame(input bit use1, input logic [15:0] d, input bit inject);
    bit exp_bits[$];
    int cpb;
    int len;
    bit e_txd, e_busy, e_rdy, e_done;
    cpb = use1 ? 1 : 4;
    sel = use1;
    #1;
    tests_run++;
    if (rdy_m !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_before_write d=%h: got %b expected 1", d, rdy_m);
    end
    exp_bits.push_back(1'b0);
    for (int b = 0; b < 16; b++) exp_bits.push_back(d[b]);
`ifdef SS_TX_PARITY_EN
    exp_bits.push_back(($countones(d) % 2) == 1);
`endif
    exp_bits.push_back(1'b1);
    len = exp_bits.size() * cpb;

    data = d;
    wr1  = use1;
    wr4  = !use1;
    @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i <= len; i++) begin
      e_txd  = (i < len) ? exp_bits[i / cpb] : 1'b1;
      e_busy = (i < len);
      e_rdy  = (i == len);
      e_done = (i == len - 1);
      tests_run += 4;
      if (txd_m !== e_txd) begin
        tests_failed++;
        $display("FAIL txd d=%h cpb=%0d i=%0d: got %b expected %b", d, cpb, i, txd_m, e_txd);
      end
      if (busy_m !== e_busy) begin
        tests_failed++;
        $display("FAIL tx_busy d=%h cpb=%0d i=%0d: got %b expected %b", d, cpb, i, busy_m, e_busy);
      end
      if (rdy_m !== e_rdy) begin
        tests_failed++;
        $display("FAIL tx_ready d=%h cpb=%0d i=%0d: got %b expected %b", d, cpb, i, rdy_m, e_rdy);
      end
      if (done_m !== e_done) begin
        tests_failed++;
        $display("FAIL tx_done d=%h cpb=%0d i=%0d: got %b expected %b", d, cpb, i, done_m, e_done);
      end
      if (i < len) begin
        if (inject && (i == len / 2 || i == len - 1)) begin
          data = 16'hFFFF;
          wr1  = use1;
          wr4  = !use1;
        end else begin
          data = 16'($urandom);
          wr1  = 1'b0;
          wr4  = 1'b0;
        end
        @(negedge CLK);
      end else begin
        wr1 = 1'b0;
        wr4 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    tests_run += 8;
    if (txd4 !== 1'b1)  begin tests_failed++; $display("FAIL reset_txd4: got %b expected 1", txd4); end
    if (rdy4 !== 1'b1)  begin tests_failed++; $display("FAIL reset_ready4: got %b expected 1", rdy4); end
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
    if (done4 !== 1'b0) begin tests_failed++; $display("FAIL reset_done4: got %b expected 0", done4); end
    if (txd1 !== 1'b1)  begin tests_failed++; $display("FAIL reset_txd1: got %b expected 1", txd1); end
    if (rdy1 !== 1'b1)  begin tests_failed++; $display("FAIL reset_ready1: got %b expected 1", rdy1); end
    if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    if (done1 !== 1'b0) begin tests_failed++; $display("FAIL reset_done1: got %b expected 0", done1); end
  endtask

  task automatic test_basic_frame();
    repeat (3) @(negedge CLK);
    send_frame(1'b0, 16'hA5C3, 1'b0);
  endtask

  task automatic test_ignored_write();
    repeat (2) @(negedge CLK);
    send_frame(1'b0, 16'hA5C3, 1'b1);
  endtask

  task automatic test_back_to_back();
    repeat (2) @(negedge CLK);
    send_frame(1'b0, 16'h0001, 1'b0);
    send_frame(1'b0, 16'h8000, 1'b0);
    send_frame(1'b1, 16'h0001, 1'b0);
    send_frame(1'b1, 16'h8000, 1'b1);
  endtask

  task automatic test_cpb1();
    repeat (2) @(negedge CLK);
    send_frame(1'b1, 16'h0000, 1'b0);
  endtask

  task automatic test_parity();
`ifdef SS_TX_PARITY_EN
    repeat (2) @(negedge CLK);
    send_frame(1'b0, 16'h0001, 1'b0);
    send_frame(1'b0, 16'hA5C3, 1'b0);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send_frame(bit'($urandom_range(0, 1)), 16'($urandom), bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_frame();
    repeat (2) @(negedge CLK);
    sel  = 1'b0;
    data = 16'h0000;
    wr4  = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    wr4 = 1'b0;
    repeat (20) @(negedge CLK);
    tests_run++;
    if (txd4 !== 1'b0) begin tests_failed++; $display("FAIL mid_data_txd: got %b expected 0", txd4); end
    #2 reset = 1'b0;
    #1;
    tests_run += 4;
    if (txd4 !== 1'b1)  begin tests_failed++; $display("FAIL async_reset_txd: got %b expected 1", txd4); end
    if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL async_reset_busy: got %b expected 0", busy4); end
    if (rdy4 !== 1'b1)  begin tests_failed++; $display("FAIL async_reset_ready: got %b expected 1", rdy4); end
    if (done4 !== 1'b0) begin tests_failed++; $display("FAIL async_reset_done: got %b expected 0", done4); end
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run += 2;
    if (txd4 !== 1'b1) begin tests_failed++; $display("FAIL post_abort_txd: got %b expected 1", txd4); end
    if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL post_abort_ready: got %b expected 1", rdy4); end
    send_frame(1'b0, 16'h3C5A, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    data  = 16'h0000;
    wr4   = 1'b0;
    wr1   = 1'b0;
    sel   = 1'b0;
    test_reset();
    test_basic_frame();
    test_ignored_write();
    test_back_to_back();
    test_cpb1();
    test_parity();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
